// File: rtl/multicycle_controller_pkg.sv
// Shared constants for the multicycle MIPS controller:
// opcodes, funct codes, state encodings and datapath select codes.
package multicycle_controller_pkg;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_READ  = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WRITE = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_JAL       = 4'd10,
        S_JR        = 4'd11,
        S_I_EXEC    = 4'd12,
        S_I_WB      = 4'd13
    } state_t;

    typedef enum logic [1:0] {
        CLS_ADD = 2'd0,
        CLS_SUB = 2'd1,
        CLS_R   = 2'd2,
        CLS_I   = 2'd3
    } alu_class_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [5:0] OP_JAL  = 6'b000011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_BNE  = 6'b000101;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_SLTI = 6'b001010;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;

    localparam logic [5:0] FN_JR  = 6'b001000;
    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b100;

    localparam logic [1:0] DST_RT = 2'b00;
    localparam logic [1:0] DST_RD = 2'b01;
    localparam logic [1:0] DST_RA = 2'b10;

    localparam logic [1:0] WB_ALU = 2'b00;
    localparam logic [1:0] WB_MDR = 2'b01;
    localparam logic [1:0] WB_PC  = 2'b10;

    localparam logic [1:0] SRCB_B     = 2'b00;
    localparam logic [1:0] SRCB_FOUR  = 2'b01;
    localparam logic [1:0] SRCB_IMM   = 2'b10;
    localparam logic [1:0] SRCB_IMMSH = 2'b11;

    localparam logic [1:0] PC_ALU    = 2'b00;
    localparam logic [1:0] PC_JUMP   = 2'b01;
    localparam logic [1:0] PC_ALUOUT = 2'b10;

endpackage

// File: rtl/multicycle_controller_alu_control.sv
// ALU operation decode from the controller's state class,
// the opcode (I-type) and the funct field (R-type).
module alu_control
    import multicycle_controller_pkg::*;
(
    input  alu_class_t  cls,
    input  logic [5:0]  opcode,
    input  logic [5:0]  funct,
    output logic [2:0]  alu_op,
    output logic        illegal_funct
);

    always_comb begin
        alu_op        = ALU_ADD;
        illegal_funct = 1'b0;
        unique case (cls)
            CLS_ADD: alu_op = ALU_ADD;
            CLS_SUB: alu_op = ALU_SUB;
            CLS_R: begin
                case (funct)
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_SLT:  alu_op = ALU_SLT;
                    default: illegal_funct = 1'b1;
                endcase
            end
            CLS_I: begin
                case (opcode)
                    OP_SLTI: alu_op = ALU_SLT;
                    OP_ANDI: alu_op = ALU_AND;
                    default: alu_op = ALU_ADD;
                endcase
            end
            default: alu_op = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle MIPS control FSM: sequences fetch, decode, execute,
// memory and writeback by driving every dataPath strobe and select.
module multicycle_controller
    import multicycle_controller_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [5:0] cbit,
    input  logic [5:0] alucbit,
    input  logic       zero,
    output logic       PCwritecnt,
    output logic       PCwritecondbeq,
    output logic       PCwritecondbne,
    output logic       IorD,
    output logic       memread,
    output logic       memwrite,
    output logic       IRwrite,
    output logic       regWrite,
    output logic [1:0] regDst,
    output logic [1:0] memtoreg,
    output logic       alusrcA,
    output logic [1:0] alusrcB,
    output logic [2:0] aluOp,
    output logic [1:0] pcSrc,
    output logic       illegal
);

    state_t     state_q;
    state_t     state_d;
    alu_class_t cls;
    logic [2:0] dec_op;
    logic       dec_illegal;

    // zero is consumed by the datapath's conditional PC write, not here
    logic unused_zero;
    assign unused_zero = zero;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state_q <= S_FETCH;
        else
            state_q <= state_d;
    end

    always_comb begin
        cls = CLS_ADD;
        unique case (state_q)
            S_R_EXEC: cls = CLS_R;
            S_I_EXEC: cls = CLS_I;
            S_BRANCH: cls = CLS_SUB;
            default:  cls = CLS_ADD;
        endcase
    end

    alu_control u_alu_control (
        .cls           (cls),
        .opcode        (cbit),
        .funct         (alucbit),
        .alu_op        (dec_op),
        .illegal_funct (dec_illegal)
    );

    always_comb begin
        state_d        = S_FETCH;
        PCwritecnt     = 1'b0;
        PCwritecondbeq = 1'b0;
        PCwritecondbne = 1'b0;
        IorD           = 1'b0;
        memread        = 1'b0;
        memwrite       = 1'b0;
        IRwrite        = 1'b0;
        regWrite       = 1'b0;
        regDst         = DST_RT;
        memtoreg       = WB_ALU;
        alusrcA        = 1'b0;
        alusrcB        = SRCB_B;
        aluOp          = ALU_ADD;
        pcSrc          = PC_ALU;
        illegal        = 1'b0;
        if (!rst) begin
            unique case (state_q)
                S_FETCH: begin
                    memread    = 1'b1;
                    IRwrite    = 1'b1;
                    alusrcB    = SRCB_FOUR;
                    PCwritecnt = 1'b1;
                    state_d    = S_DECODE;
                end
                S_DECODE: begin
                    alusrcB = SRCB_IMMSH;
                    case (cbit)
                        OP_R:
                            state_d = (alucbit == FN_JR) ? S_JR : S_R_EXEC;
                        OP_LW, OP_SW:     state_d = S_MEM_ADDR;
                        OP_BEQ, OP_BNE:   state_d = S_BRANCH;
                        OP_J:             state_d = S_JUMP;
                        OP_JAL:           state_d = S_JAL;
                        OP_ADDI, OP_SLTI,
                        OP_ANDI:          state_d = S_I_EXEC;
                        default:          illegal = 1'b1;
                    endcase
                end
                S_MEM_ADDR: begin
                    alusrcA = 1'b1;
                    alusrcB = SRCB_IMM;
                    if (cbit == OP_LW)
                        state_d = S_MEM_READ;
                    else if (cbit == OP_SW)
                        state_d = S_MEM_WRITE;
                end
                S_MEM_READ: begin
                    memread = 1'b1;
                    IorD    = 1'b1;
                    state_d = S_MEM_WB;
                end
                S_MEM_WB: begin
                    regWrite = 1'b1;
                    regDst   = DST_RT;
                    memtoreg = WB_MDR;
                end
                S_MEM_WRITE: begin
                    memwrite = 1'b1;
                    IorD     = 1'b1;
                end
                S_R_EXEC: begin
                    alusrcA = 1'b1;
                    alusrcB = SRCB_B;
                    aluOp   = dec_op;
                    illegal = dec_illegal;
                    state_d = dec_illegal ? S_FETCH : S_R_WB;
                end
                S_R_WB: begin
                    regWrite = 1'b1;
                    regDst   = DST_RD;
                    memtoreg = WB_ALU;
                end
                S_BRANCH: begin
                    alusrcA        = 1'b1;
                    alusrcB        = SRCB_B;
                    aluOp          = dec_op;
                    pcSrc          = PC_ALUOUT;
                    PCwritecondbeq = (cbit == OP_BEQ);
                    PCwritecondbne = (cbit == OP_BNE);
                end
                S_JUMP: begin
                    pcSrc      = PC_JUMP;
                    PCwritecnt = 1'b1;
                end
                S_JAL: begin
                    pcSrc      = PC_JUMP;
                    PCwritecnt = 1'b1;
                    regWrite   = 1'b1;
                    regDst     = DST_RA;
                    memtoreg   = WB_PC;
                end
                S_JR: begin
                    alusrcA    = 1'b1;
                    alusrcB    = SRCB_B;
                    aluOp      = ALU_ADD;
                    pcSrc      = PC_ALU;
                    PCwritecnt = 1'b1;
                end
                S_I_EXEC: begin
                    alusrcA = 1'b1;
                    alusrcB = SRCB_IMM;
                    aluOp   = dec_op;
                    state_d = S_I_WB;
                end
                S_I_WB: begin
                    regWrite = 1'b1;
                    regDst   = DST_RT;
                    memtoreg = WB_ALU;
                end
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench for multicycle_controller: walks every instruction
// class and compares the full control word against hand-derived values.
module tb_multicycle_controller;

    logic       clk;
    logic       rst;
    logic [5:0] cbit;
    logic [5:0] alucbit;
    logic       zero;
    logic       PCwritecnt, PCwritecondbeq, PCwritecondbne;
    logic       IorD, memread, memwrite, IRwrite, regWrite;
    logic [1:0] regDst, memtoreg, alusrcB, pcSrc;
    logic       alusrcA, illegal;
    logic [2:0] aluOp;

    int checks = 0;
    int errors = 0;
    bit mon_en = 0;

    multicycle_controller dut (
        .clk            (clk),
        .rst            (rst),
        .cbit           (cbit),
        .alucbit        (alucbit),
        .zero           (zero),
        .PCwritecnt     (PCwritecnt),
        .PCwritecondbeq (PCwritecondbeq),
        .PCwritecondbne (PCwritecondbne),
        .IorD           (IorD),
        .memread        (memread),
        .memwrite       (memwrite),
        .IRwrite        (IRwrite),
        .regWrite       (regWrite),
        .regDst         (regDst),
        .memtoreg       (memtoreg),
        .alusrcA        (alusrcA),
        .alusrcB        (alusrcB),
        .aluOp          (aluOp),
        .pcSrc          (pcSrc),
        .illegal        (illegal)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [20:0] ctrl;
    assign ctrl = {PCwritecnt, PCwritecondbeq, PCwritecondbne, IorD,
                   memread, memwrite, IRwrite, regWrite, regDst,
                   memtoreg, alusrcA, alusrcB, aluOp, pcSrc, illegal};

    function automatic logic [20:0] ctl(
        input logic pcw, beq, bne, iord, mr, mw, irw, rw,
        input logic [1:0] rd, mtr,
        input logic asa,
        input logic [1:0] asb,
        input logic [2:0] op,
        input logic [1:0] pcs,
        input logic ill);
        return {pcw, beq, bne, iord, mr, mw, irw, rw, rd, mtr,
                asa, asb, op, pcs, ill};
    endfunction

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cyc(input string tag, input logic [20:0] exp);
        check(tag, {11'b0, ctrl}, {11'b0, exp});
        @(negedge clk);
        #1;
    endtask

    // Datapath-level PC write enable, as dataPath would combine it
    function automatic logic pc_write_eff();
        return PCwritecnt | (PCwritecondbeq & zero) |
               (PCwritecondbne & ~zero);
    endfunction

    always @(negedge clk) begin
        if (mon_en) begin
            check("pcw_excl", 32'($countones({PCwritecnt, PCwritecondbeq,
                  PCwritecondbne}) <= 1), 32'd1);
            check("mem_excl", 32'(memread & memwrite), 32'd0);
        end
    end

    logic [20:0] e_fetch, e_dec, e_dec_ill, e_maddr, e_mrd, e_mwb;
    logic [20:0] e_mwr, e_rwb, e_jump, e_jal, e_jr, e_iwb;

    function automatic logic [20:0] e_rexec(input logic [2:0] op,
                                            input logic ill);
        return ctl(0,0,0,0,0,0,0,0,2'b00,2'b00,1,2'b00,op,2'b00,ill);
    endfunction

    function automatic logic [20:0] e_iexec(input logic [2:0] op);
        return ctl(0,0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,op,2'b00,0);
    endfunction

    function automatic logic [20:0] e_br(input logic beq, bne);
        return ctl(0,beq,bne,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b001,2'b10,0);
    endfunction

    task automatic instr(input logic [5:0] op, input logic [5:0] fn);
        cbit    = op;
        alucbit = fn;
    endtask

    initial begin
        e_fetch   = ctl(1,0,0,0,1,0,1,0,2'b00,2'b00,0,2'b01,3'b000,2'b00,0);
        e_dec     = ctl(0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b000,2'b00,0);
        e_dec_ill = ctl(0,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b11,3'b000,2'b00,1);
        e_maddr   = ctl(0,0,0,0,0,0,0,0,2'b00,2'b00,1,2'b10,3'b000,2'b00,0);
        e_mrd     = ctl(0,0,0,1,1,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0);
        e_mwb     = ctl(0,0,0,0,0,0,0,1,2'b00,2'b01,0,2'b00,3'b000,2'b00,0);
        e_mwr     = ctl(0,0,0,1,0,1,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b00,0);
        e_rwb     = ctl(0,0,0,0,0,0,0,1,2'b01,2'b00,0,2'b00,3'b000,2'b00,0);
        e_jump    = ctl(1,0,0,0,0,0,0,0,2'b00,2'b00,0,2'b00,3'b000,2'b01,0);
        e_jal     = ctl(1,0,0,0,0,0,0,1,2'b10,2'b10,0,2'b00,3'b000,2'b01,0);
        e_jr      = ctl(1,0,0,0,0,0,0,0,2'b00,2'b00,1,2'b00,3'b000,2'b00,0);
        e_iwb     = ctl(0,0,0,0,0,0,0,1,2'b00,2'b00,0,2'b00,3'b000,2'b00,0);

        rst = 1'b1; cbit = 6'b100011; alucbit = 6'b0; zero = 1'b0;
        #3;
        check("reset_outs", {11'b0, ctrl}, 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        mon_en = 1;

        // lw aborted by reset in MEM_READ
        instr(6'b100011, 6'b0);
        cyc("rst_lw_fetch", e_fetch);
        cyc("rst_lw_dec", e_dec);
        cyc("rst_lw_maddr", e_maddr);
        check("rst_lw_mrd", {11'b0, ctrl}, {11'b0, e_mrd});
        rst = 1'b1;
        #1;
        check("rst_async", {11'b0, ctrl}, 32'd0);
        @(negedge clk);
        #1;
        check("rst_hold", {11'b0, ctrl}, 32'd0);
        rst = 1'b0;
        #1;

        // lw full, 5 cycles
        cyc("lw_fetch", e_fetch);
        cyc("lw_dec", e_dec);
        cyc("lw_maddr", e_maddr);
        cyc("lw_mrd", e_mrd);
        cyc("lw_mwb", e_mwb);

        instr(6'b101011, 6'b0);
        cyc("sw_fetch", e_fetch);
        cyc("sw_dec", e_dec);
        cyc("sw_maddr", e_maddr);
        cyc("sw_mwr", e_mwr);

        instr(6'b000000, 6'b100000);
        cyc("add_fetch", e_fetch);
        cyc("add_dec", e_dec);
        cyc("add_exec", e_rexec(3'b000, 0));
        cyc("add_wb", e_rwb);

        instr(6'b000000, 6'b101010);
        cyc("slt_fetch", e_fetch);
        cyc("slt_dec", e_dec);
        cyc("slt_exec", e_rexec(3'b100, 0));
        cyc("slt_wb", e_rwb);

        instr(6'b000000, 6'b100010);
        cyc("sub_fetch", e_fetch);
        cyc("sub_dec", e_dec);
        cyc("sub_exec", e_rexec(3'b001, 0));
        cyc("sub_wb", e_rwb);

        instr(6'b000100, 6'b0);
        zero = 1'b1;
        cyc("beq_fetch", e_fetch);
        cyc("beq_dec", e_dec);
        check("beq_pcwrite", 32'(pc_write_eff()), 32'd1);
        cyc("beq_br", e_br(1, 0));

        instr(6'b000101, 6'b0);
        cyc("bne_fetch", e_fetch);
        cyc("bne_dec", e_dec);
        check("bne_pcwrite", 32'(pc_write_eff()), 32'd0);
        cyc("bne_br", e_br(0, 1));
        zero = 1'b0;

        instr(6'b000010, 6'b0);
        cyc("j_fetch", e_fetch);
        cyc("j_dec", e_dec);
        cyc("j_jump", e_jump);

        instr(6'b000011, 6'b0);
        cyc("jal_fetch", e_fetch);
        cyc("jal_dec", e_dec);
        cyc("jal_jal", e_jal);

        instr(6'b000000, 6'b001000);
        cyc("jr_fetch", e_fetch);
        cyc("jr_dec", e_dec);
        cyc("jr_jr", e_jr);

        instr(6'b001000, 6'b0);
        cyc("addi_fetch", e_fetch);
        cyc("addi_dec", e_dec);
        cyc("addi_exec", e_iexec(3'b000));
        cyc("addi_wb", e_iwb);

        instr(6'b001010, 6'b0);
        cyc("slti_fetch", e_fetch);
        cyc("slti_dec", e_dec);
        cyc("slti_exec", e_iexec(3'b100));
        cyc("slti_wb", e_iwb);

        instr(6'b001100, 6'b0);
        cyc("andi_fetch", e_fetch);
        cyc("andi_dec", e_dec);
        cyc("andi_exec", e_iexec(3'b010));
        cyc("andi_wb", e_iwb);

        instr(6'b111111, 6'b0);
        cyc("ill_op_fetch", e_fetch);
        cyc("ill_op_dec", e_dec_ill);

        instr(6'b000000, 6'b000111);
        cyc("ill_fn_fetch", e_fetch);
        cyc("ill_fn_dec", e_dec);
        cyc("ill_fn_exec", e_rexec(3'b000, 1));

        instr(6'b000000, 6'b100101);
        cyc("or_fetch", e_fetch);
        cyc("or_dec", e_dec);
        cyc("or_exec", e_rexec(3'b011, 0));
        cyc("or_wb", e_rwb);

        check("final_fetch", {11'b0, ctrl}, {11'b0, e_fetch});
        mon_en = 0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
